// File: rtl/morse_seq_frontend.sv
// Morse key front end: edge-detects Dot/Dash/Space/EndSeq key levels into a
// one-cycle symbol code, packs dots/dashes into a letter of up to MAX_SYMS
// symbols, and keeps the first two (then the latest two) non-empty letters
// of the current message in FirstSeq/SecSeq.
module morse_seq_frontend #(
    parameter int          MAX_SYMS   = 5,
    parameter logic [1:0]  EMPTY_CODE = 2'b11
) (
    input  logic                    Clk,
    input  logic                    Resetbar,
    input  logic                    Dot,
    input  logic                    Dash,
    input  logic                    Space,
    input  logic                    EndSeq,
    input  logic                    Clear,
    output logic [2:0]              Signals,
    output logic [2*MAX_SYMS-1:0]   EncSeq,
    output logic                    Space_EndSeqbar,
    output logic                    SentFlag,
    output logic                    MsgFlag,
    output logic [2*MAX_SYMS-1:0]   FirstSeq,
    output logic [2*MAX_SYMS-1:0]   SecSeq
);

    localparam int             SEQ_W     = 2 * MAX_SYMS;
    localparam int             CNT_W     = $clog2(MAX_SYMS + 1);
    localparam logic [SEQ_W-1:0] EMPTY_SEQ = {MAX_SYMS{EMPTY_CODE}};
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_SYMS);

    localparam logic [2:0] SIG_NONE  = 3'b000;
    localparam logic [2:0] SIG_DOT   = 3'b001;
    localparam logic [2:0] SIG_DASH  = 3'b010;
    localparam logic [2:0] SIG_SPACE = 3'b011;
    localparam logic [2:0] SIG_END   = 3'b100;

    // Encoder state
    logic [3:0]        r_key_prev;
    logic [2:0]        r_signals;
    // Producer state
    logic [SEQ_W-1:0]  r_enc_seq;
    logic [CNT_W-1:0]  r_count;
    logic              r_sent_flag;
    logic              r_space_endseqbar;
    // Separator state
    logic [SEQ_W-1:0]  r_first_seq;
    logic [SEQ_W-1:0]  r_sec_seq;
    logic [1:0]        r_slot_idx;
    logic              r_msg_flag;
    logic              r_msg_done;

    logic [3:0]        w_keys;
    logic [3:0]        w_rise;
    logic [2:0]        w_sig_code;
    logic [SEQ_W-1:0]  w_base_seq;
    logic [CNT_W-1:0]  w_base_cnt;
    logic [SEQ_W-1:0]  w_sym_seq;

    assign w_keys = {EndSeq, Space, Dash, Dot};
    assign w_rise = w_keys & ~r_key_prev;

    // Priority-encode simultaneous key events; lower-priority ones are dropped
    always_comb begin
        w_sig_code = SIG_NONE;
        if (w_rise[3])      w_sig_code = SIG_END;
        else if (w_rise[2]) w_sig_code = SIG_SPACE;
        else if (w_rise[1]) w_sig_code = SIG_DASH;
        else if (w_rise[0]) w_sig_code = SIG_DOT;
    end

    // A letter shown with SentFlag is discarded on the following edge, so the
    // next symbol builds on an empty letter rather than on the finished one
    always_comb begin
        w_base_seq = r_sent_flag ? EMPTY_SEQ : r_enc_seq;
        w_base_cnt = r_sent_flag ? '0 : r_count;
        w_sym_seq  = w_base_seq;
        for (int p = 0; p < MAX_SYMS; p++) begin
            if (p == int'(w_base_cnt))
                w_sym_seq[SEQ_W-1-2*p -: 2] = (r_signals == SIG_DASH) ? 2'b01 : 2'b00;
        end
    end

    // Encoder: key history and one-cycle symbol code
    always_ff @(posedge Clk) begin
        if (!Resetbar) begin
            r_key_prev <= '0;
            r_signals  <= SIG_NONE;
        end else begin
            r_key_prev <= w_keys;
            r_signals  <= w_sig_code;
        end
    end

    // Producer: pack symbols into the letter and flag terminators
    always_ff @(posedge Clk) begin
        if (!Resetbar) begin
            r_enc_seq         <= EMPTY_SEQ;
            r_count           <= '0;
            r_sent_flag       <= 1'b0;
            r_space_endseqbar <= 1'b0;
        end else begin
            r_sent_flag <= 1'b0;
            if (Clear) begin
                r_enc_seq <= EMPTY_SEQ;
                r_count   <= '0;
            end else begin
                r_enc_seq <= w_base_seq;
                r_count   <= w_base_cnt;
                case (r_signals)
                    SIG_DOT, SIG_DASH: begin
                        if (w_base_cnt < MAX_CNT) begin
                            r_enc_seq <= w_sym_seq;
                            r_count   <= w_base_cnt + 1'b1;
                        end
                    end
                    SIG_SPACE, SIG_END: begin
                        r_sent_flag       <= 1'b1;
                        r_space_endseqbar <= (r_signals == SIG_SPACE);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Separator: store finished non-empty letters and signal end of message
    always_ff @(posedge Clk) begin
        if (!Resetbar) begin
            r_first_seq <= EMPTY_SEQ;
            r_sec_seq   <= EMPTY_SEQ;
            r_slot_idx  <= 2'd0;
            r_msg_flag  <= 1'b0;
            r_msg_done  <= 1'b0;
        end else begin
            r_msg_flag <= 1'b0;
            if (r_sent_flag) begin
                if (r_enc_seq != EMPTY_SEQ) begin
                    r_msg_done <= 1'b0;
                    if (r_msg_done) begin
                        // New message: old slots are dropped before storing
                        r_first_seq <= r_enc_seq;
                        r_sec_seq   <= EMPTY_SEQ;
                        r_slot_idx  <= 2'd1;
                    end else begin
                        case (r_slot_idx)
                            2'd0: begin
                                r_first_seq <= r_enc_seq;
                                r_slot_idx  <= 2'd1;
                            end
                            2'd1: begin
                                r_sec_seq  <= r_enc_seq;
                                r_slot_idx <= 2'd2;
                            end
                            default: begin
                                r_first_seq <= r_sec_seq;
                                r_sec_seq   <= r_enc_seq;
                            end
                        endcase
                    end
                end
                if (!r_space_endseqbar) begin
                    r_msg_flag <= 1'b1;
                    r_msg_done <= 1'b1;
                end
            end
        end
    end

    assign Signals         = r_signals;
    assign EncSeq          = r_enc_seq;
    assign Space_EndSeqbar = r_space_endseqbar;
    assign SentFlag        = r_sent_flag;
    assign MsgFlag         = r_msg_flag;
    assign FirstSeq        = r_first_seq;
    assign SecSeq          = r_sec_seq;

endmodule

// File: tb/tb_morse_seq_frontend.sv
// Directed bench for morse_seq_frontend: key presses driven 1 ns after each
// rising edge, outputs checked 1 ns after the edge that updates them.
module tb_morse_seq_frontend;

    logic       Clk = 1'b0;
    logic       Resetbar = 1'b0;
    logic       Dot = 1'b0, Dash = 1'b0, Space = 1'b0, EndSeq = 1'b0, Clear = 1'b0;
    logic [2:0] Signals;
    logic [9:0] EncSeq, FirstSeq, SecSeq;
    logic       Space_EndSeqbar, SentFlag, MsgFlag;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] K_DOT = 4'b0001, K_DASH = 4'b0010, K_SPACE = 4'b0100, K_END = 4'b1000;

    morse_seq_frontend dut (
        .Clk(Clk), .Resetbar(Resetbar), .Dot(Dot), .Dash(Dash), .Space(Space),
        .EndSeq(EndSeq), .Clear(Clear), .Signals(Signals), .EncSeq(EncSeq),
        .Space_EndSeqbar(Space_EndSeqbar), .SentFlag(SentFlag), .MsgFlag(MsgFlag),
        .FirstSeq(FirstSeq), .SecSeq(SecSeq)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Raise the given keys for one cycle; returns 1 ns after the edge that
    // consumed the symbol (EncSeq/SentFlag updated there)
    task automatic press(input logic [3:0] k, input logic [2:0] exp_sig, input string tag);
        {EndSeq, Space, Dash, Dot} = k;
        tick();
        check({tag, "_sig"}, 32'(Signals), 32'(exp_sig));
        {EndSeq, Space, Dash, Dot} = 4'b0000;
        tick();
        check({tag, "_sig0"}, 32'(Signals), 32'd0);
        $display("txn %s: Signals=%0d EncSeq=%03h Sent=%0b SE=%0b", tag, exp_sig, EncSeq, SentFlag, Space_EndSeqbar);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sig"},   32'(Signals),         32'd0);
        check({tag, "_enc"},   32'(EncSeq),          32'h3FF);
        check({tag, "_se"},    32'(Space_EndSeqbar), 32'd0);
        check({tag, "_sent"},  32'(SentFlag),        32'd0);
        check({tag, "_msg"},   32'(MsgFlag),         32'd0);
        check({tag, "_first"}, 32'(FirstSeq),        32'h3FF);
        check({tag, "_sec"},   32'(SecSeq),          32'h3FF);
    endtask

    initial begin
        // Reset, with a key held to show reset overrides it
        Resetbar = 1'b0;
        Dot = 1'b1;
        tick();
        tick();
        check_reset("rst");
        Dot = 1'b0;
        tick();
        Resetbar = 1'b1;
        tick();

        // Dot Dash Dot Dot Dash EndSeq -> 00_01_00_00_01
        press(K_DOT,  3'b001, "m1_dot");
        check("m1_enc_p0", 32'(EncSeq), 32'h0FF);
        press(K_DASH, 3'b010, "m1_dash");
        check("m1_enc_p1", 32'(EncSeq), 32'h07F);
        press(K_DOT,  3'b001, "m1_dot");
        press(K_DOT,  3'b001, "m1_dot");
        press(K_DASH, 3'b010, "m1_dash");
        check("m1_sent_before", 32'(SentFlag), 32'd0);
        press(K_END,  3'b100, "m1_end");
        check("m1_enc",  32'(EncSeq),          32'h041);
        check("m1_sent", 32'(SentFlag),        32'd1);
        check("m1_se",   32'(Space_EndSeqbar), 32'd0);
        check("m1_msg0", 32'(MsgFlag),         32'd0);
        tick();
        check("m1_msg",   32'(MsgFlag),  32'd1);
        check("m1_first", 32'(FirstSeq), 32'h041);
        check("m1_sec",   32'(SecSeq),   32'h3FF);
        check("m1_sent_off", 32'(SentFlag), 32'd0);
        check("m1_enc_clr",  32'(EncSeq),   32'h3FF);
        tick();
        check("m1_msg_off", 32'(MsgFlag), 32'd0);

        // Lone Space: empty letter, slots unchanged
        press(K_SPACE, 3'b011, "sp_alone");
        check("sp_sent", 32'(SentFlag),        32'd1);
        check("sp_se",   32'(Space_EndSeqbar), 32'd1);
        check("sp_enc",  32'(EncSeq),          32'h3FF);
        tick();
        check("sp_msg",   32'(MsgFlag),  32'd0);
        check("sp_first", 32'(FirstSeq), 32'h041);
        check("sp_sec",   32'(SecSeq),   32'h3FF);

        // Dot Dot Dot Dash Dash Space: new message clears old slots
        press(K_DOT,  3'b001, "m2_dot");
        press(K_DOT,  3'b001, "m2_dot");
        press(K_DOT,  3'b001, "m2_dot");
        press(K_DASH, 3'b010, "m2_dash");
        press(K_DASH, 3'b010, "m2_dash");
        press(K_SPACE, 3'b011, "m2_space");
        check("m2_enc", 32'(EncSeq), 32'h005);
        check("m2_se",  32'(Space_EndSeqbar), 32'd1);
        tick();
        check("m2_first", 32'(FirstSeq), 32'h005);
        check("m2_sec",   32'(SecSeq),   32'h3FF);
        check("m2_msg0",  32'(MsgFlag),  32'd0);
        press(K_END, 3'b100, "m2_end");
        check("m2_end_enc", 32'(EncSeq), 32'h3FF);
        check("m2_end_se",  32'(Space_EndSeqbar), 32'd0);
        tick();
        check("m2_msg",   32'(MsgFlag),  32'd1);
        check("m2_first2", 32'(FirstSeq), 32'h005);
        check("m2_sec2",   32'(SecSeq),   32'h3FF);

        // Three letters: fill both slots, then shift
        press(K_DASH,  3'b010, "m3_l1_dash");
        press(K_SPACE, 3'b011, "m3_l1_space");
        tick();
        check("m3_l1_first", 32'(FirstSeq), 32'h1FF);
        check("m3_l1_sec",   32'(SecSeq),   32'h3FF);
        press(K_DOT,   3'b001, "m3_l2_dot");
        press(K_SPACE, 3'b011, "m3_l2_space");
        tick();
        check("m3_l2_first", 32'(FirstSeq), 32'h1FF);
        check("m3_l2_sec",   32'(SecSeq),   32'h0FF);
        press(K_DASH,  3'b010, "m3_l3_dash");
        press(K_DASH,  3'b010, "m3_l3_dash");
        press(K_SPACE, 3'b011, "m3_l3_space");
        check("m3_l3_enc", 32'(EncSeq), 32'h17F);
        tick();
        check("m3_l3_first", 32'(FirstSeq), 32'h0FF);
        check("m3_l3_sec",   32'(SecSeq),   32'h17F);
        press(K_END, 3'b100, "m3_end");
        tick();
        check("m3_msg", 32'(MsgFlag), 32'd1);

        // Six dots: sixth dropped, no flag
        for (int i = 0; i < 6; i++) press(K_DOT, 3'b001, "m4_dot");
        check("m4_enc6",  32'(EncSeq),   32'h000);
        check("m4_sent6", 32'(SentFlag), 32'd0);
        press(K_SPACE, 3'b011, "m4_space");
        check("m4_enc",  32'(EncSeq),   32'h000);
        check("m4_sent", 32'(SentFlag), 32'd1);
        tick();
        check("m4_first", 32'(FirstSeq), 32'h000);
        check("m4_sec",   32'(SecSeq),   32'h3FF);

        // Dot+Dash on the same edge -> dash only
        press(K_DOT | K_DASH, 3'b010, "both");
        check("both_enc", 32'(EncSeq), 32'h1FF);

        // Dot then Clear
        press(K_DOT, 3'b001, "clr_dot");
        check("clr_enc_pre", 32'(EncSeq), 32'h13F);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_enc",  32'(EncSeq),   32'h3FF);
        check("clr_first", 32'(FirstSeq), 32'h000);
        $display("txn clear: EncSeq=%03h", EncSeq);

        // Symbol arriving on the Clear edge is lost
        Dot = 1'b1;
        tick();
        Dot = 1'b0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_lost_enc", 32'(EncSeq), 32'h3FF);
        tick();
        check("clr_lost_enc2", 32'(EncSeq), 32'h3FF);

        // Mid-run reset
        press(K_DASH, 3'b010, "rst2_dash");
        Resetbar = 1'b0;
        tick();
        check_reset("rst2");
        Resetbar = 1'b1;
        tick();

        // EndSeq after reset: empty letter ends the message
        press(K_END, 3'b100, "rst2_end");
        check("rst2_end_sent", 32'(SentFlag), 32'd1);
        check("rst2_end_enc",  32'(EncSeq),   32'h3FF);
        tick();
        check("rst2_msg",   32'(MsgFlag),  32'd1);
        check("rst2_first", 32'(FirstSeq), 32'h3FF);
        check("rst2_sec",   32'(SecSeq),   32'h3FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
